// File: rtl/bus_rr_scheduler.sv
// Round-robin bus scheduler: picks one pending device, pops its head packet
// and forwards it to the addressed device(s) on a shared bus. A packet takes three cycles.
module bus_rr_scheduler #(
  parameter int          drvrs     = 4,
  parameter int          pckg_sz   = 32,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]           pop,
  output logic [drvrs-1:0]           push,
  output logic [pckg_sz-1:0]         D_push,
  output logic [3:0]                 grant_id,
  output logic                       busy,
  output logic [7:0]                 drop_cnt
);

  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

  localparam logic [drvrs-1:0] ONE = {{(drvrs-1){1'b0}}, 1'b1};

  state_t             state;
  logic [pckg_sz-1:0] pkt_reg;
  logic [3:0]         last_grant;
  logic [7:0]         dest_id;
  logic [drvrs-1:0]   push_mask;
  logic [drvrs-1:0]   grant_mask;

  // First requester at or after last+1, wrapping modulo drvrs.
  function automatic logic [3:0] rr_pick(input logic [drvrs-1:0] req,
                                         input logic [3:0]       last);
    logic [3:0]       pick;
    logic             found;
    logic [drvrs-1:0] shifted;
    int               start;
    int               idx;
    pick  = '0;
    found = 1'b0;
    start = (int'(last) + 1) % drvrs;
    for (int k = 0; k < drvrs; k++) begin
      idx     = (start + k) % drvrs;
      shifted = req >> idx;
      if (!found && shifted[0]) begin
        pick  = 4'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Zero mask means the packet is discarded (self-addressed or unknown ID).
  function automatic logic [drvrs-1:0] dest_mask(input logic [7:0] id,
                                                 input logic [3:0] src);
    logic [drvrs-1:0] m;
    m = '0;
    if (id == broadcast)
      m = ~(ONE << src);
    else if (int'(id) < drvrs && id != {4'd0, src})
      m = ONE << id;
    return m;
  endfunction

  assign dest_id    = pkt_reg[pckg_sz-1 -: 8];
  assign grant_mask = ONE << grant_id;

  always_comb begin
    push_mask = '0;
    push_mask = dest_mask(dest_id, grant_id);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pop        <= '0;
      push       <= '0;
      D_push     <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      drop_cnt   <= '0;
      pkt_reg    <= '0;
      last_grant <= 4'(drvrs - 1);
    end else begin
      pop  <= '0;
      push <= '0;
      case (state)
        IDLE: begin
          if (|pndng) begin
            grant_id <= rr_pick(pndng, last_grant);
            busy     <= 1'b1;
            state    <= POP;
          end
        end
        // Device may have withdrawn its request since arbitration.
        POP: begin
          if (|(pndng & grant_mask)) begin
            pop     <= grant_mask;
            pkt_reg <= D_pop[grant_id*pckg_sz +: pckg_sz];
            state   <= PUSH;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        PUSH: begin
          push       <= push_mask;
          D_push     <= pkt_reg;
          last_grant <= grant_id;
          if (push_mask == '0)
            drop_cnt <= sat_inc(drop_cnt);
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bus_rr_scheduler.md
BUS_RR_SCHEDULER -- requirements
Module: bus_rr_scheduler

Interface
REQ-001 SHALL have parameter drvrs, default 4: number of bus devices (2..16).
REQ-002 SHALL have parameter pckg_sz, default 32: packet width in bits (>= 16).
REQ-003 SHALL have parameter broadcast, default 8'hFF: destination ID meaning all devices.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port pndng, input, drvrs: device i has a packet waiting at its FIFO head.
REQ-007 SHALL have port D_pop, input, drvrs*pckg_sz: head packet of device i in bits [i*pckg_sz +: pckg_sz], valid while pndng[i]=1.
REQ-008 SHALL have port pop, output, drvrs: one-hot, one-cycle pulse; removes the head of device i.
REQ-009 SHALL have port push, output, drvrs: one-cycle pulse to each destination device.
REQ-010 SHALL have port D_push, output, pckg_sz: shared packet bus, valid while any push bit is 1.
REQ-011 SHALL have port grant_id, output, 4: index of the device currently served.
REQ-012 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-013 SHALL have port drop_cnt, output, 8: saturating count of discarded packets.

Function
REQ-014 SHALL use the packet destination ID in D_pop bits [pckg_sz-1 : pckg_sz-8].
REQ-015 SHALL implement an FSM with states IDLE, POP and PUSH.
REQ-016 IDLE SHALL stay in IDLE while pndng==0.
REQ-017 When pndng!=0 in IDLE, the FSM SHALL register grant_id as the first set bit searched from last_grant+1 modulo drvrs, then enter POP.
REQ-018 POP, pndng[grant_id]=1: SHALL assert pop[grant_id] for exactly one cycle, latch D_pop slice into pkt_reg, and enter PUSH.
REQ-019 POP, pndng[grant_id]=0: SHALL assert no pop, leave last_grant unchanged, and return to IDLE.
REQ-020 PUSH, ID==broadcast: SHALL set push to all ones except bit grant_id.
REQ-021 PUSH, ID<drvrs and ID!=grant_id: SHALL set push to one-hot at bit ID.
REQ-022 PUSH, any other ID (out of range or self-addressed): SHALL assert no push, increment drop_cnt saturating at 255, and drop the packet.
REQ-023 PUSH SHALL drive D_push=pkt_reg for that cycle, update last_grant=grant_id, and return to IDLE.
REQ-024 Timing: pop SHALL rise 1 cycle after pndng is sampled in IDLE, and push SHALL follow 1 cycle after pop; throughput is one packet per 3 cycles.
REQ-025 pop and push SHALL never be high in the same cycle, and pop SHALL never have more than one bit set.
REQ-026 Fairness: with all pndng held at 1, grants SHALL rotate 0,1,..,drvrs-1,0; no device waits more than drvrs grants.
REQ-027 D_push SHALL hold its last value when push==0; the bench checks it only when push!=0.

Reset
REQ-028 While reset=0, the block SHALL immediately force state=IDLE, pop=0, push=0, D_push=0, grant_id=0, busy=0, drop_cnt=0, pkt_reg=0, last_grant=drvrs-1.
REQ-029 Reset asserted in POP or PUSH SHALL abort the transfer with no further pop or push; the first grant after release goes to the lowest pending index.
REQ-030 After reset release, the first arbitration SHALL occur on the first rising clk edge with reset=1.

Verification
REQ-031 Unicast: pndng=4'b0001, D_pop[0]=32'h02AB_CDEF -> pop=4'b0001 at cycle N+1, push=4'b0100 with D_push=32'h02AB_CDEF at N+2.
REQ-032 Broadcast: pndng=4'b0100, packet 32'hFF00_0011 on device 2 -> push=4'b1011 for one cycle, drop_cnt unchanged.
REQ-033 Round-robin: pndng=4'b1111 held for 12 cycles -> grant_id sequence 0,1,2,3 with a pop every 3 cycles.
REQ-034 Drops: device 1 sends ID 8'h01, then ID 8'h07 -> no push for either, drop_cnt=2; with 300 drops, drop_cnt=255.
REQ-035 Withdraw: pndng[3] falls in the cycle POP is entered -> no pop, FSM back in IDLE, last_grant unchanged.
REQ-036 Mid-reset: reset=0 asserted in PUSH -> push=0 immediately; after release with pndng=4'b1010, first grant_id=1.
